// File: rtl/udp_tx_sched.sv
// udp_tx_sched: round-robin multi-channel transmit front end for the udp core.
// Arbitrates NCH payload sources, rejects illegal lengths, drives the core's
// tx_start / tx_data_req / tx_data handshake and enforces an inter-frame gap.
// Optional per-channel statistics: define UDP_TX_SCHED_STATS_EN.
module udp_tx_sched #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned MAX_LEN = 1472,
  parameter int unsigned IFG_CYC = 12
) (
  input  logic              e_rxc,
  input  logic              rst_n,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*16-1:0] ch_len,
  input  logic [NCH*16-1:0] ch_dst_port,
  input  logic [NCH*DW-1:0] ch_data,
  output logic [NCH-1:0]    ch_grant,
  output logic [NCH-1:0]    ch_err,
  output logic [NCH-1:0]    ch_data_req,
  output logic              busy,
  output logic              tx_start,
  input  logic              tx_data_req,
  output logic [DW-1:0]     tx_data,
  output logic [15:0]       tx_data_length,
  output logic [15:0]       tx_total_length,
  output logic [15:0]       dst_port
`ifdef UDP_TX_SCHED_STATS_EN
  ,
  output logic [NCH*16-1:0] stat_frames,
  output logic [NCH*16-1:0] stat_drops
`endif
);

  localparam int unsigned BPW       = DW / 8;
  localparam int unsigned LOG_BPW   = $clog2(BPW);
  localparam int unsigned PW        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned GW        = (IFG_CYC > 1) ? $clog2(IFG_CYC + 1) : 1;
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [15:0] BPW_M1    = 16'(BPW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_GAP
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic [15:0]   len_q;
  logic [15:0]   words_left;
  logic [GW-1:0] gap_cnt;

  logic [PW-1:0] arb_sel;
  logic [PW-1:0] cand;
  logic          arb_hit;
  logic [15:0]   arb_len;
  logic [15:0]   arb_port;
  logic          arb_bad;

  // Round-robin search: first requester strictly after the pointer, wrapping
  always_comb begin
    arb_hit = 1'b0;
    arb_sel = ptr;
    cand    = ptr;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = PW'((32'(ptr) + i) % NCH);
      if (!arb_hit && ch_req[cand]) begin
        arb_hit = 1'b1;
        arb_sel = cand;
      end
    end
    arb_len  = ch_len[16*arb_sel +: 16];
    arb_port = ch_dst_port[16*arb_sel +: 16];
    arb_bad  = (arb_len == '0) || (arb_len > MAX_LEN_W);
  end

  // Next-state and handshake outputs; grant/err are gated while reset is held
  // so every output reads 0 asynchronously during reset
  always_comb begin
    state_nxt   = state;
    ch_grant    = '0;
    ch_err      = '0;
    ch_data_req = '0;
    tx_data     = '0;
    tx_start    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rst_n && arb_hit) begin
          if (arb_bad) begin
            ch_err[arb_sel] = 1'b1;
          end else begin
            ch_grant[arb_sel] = 1'b1;
            state_nxt         = S_START;
          end
        end
      end
      S_START: begin
        tx_start  = 1'b1;
        state_nxt = S_DATA;
      end
      S_DATA: begin
        ch_data_req[sel] = tx_data_req;
        tx_data          = ch_data[DW*sel +: DW];
        if (tx_data_req && words_left == 16'd1) state_nxt = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt <= GW'(1)) state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

  // State register, arbitration pointer and per-frame registers
  always_ff @(posedge e_rxc or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      ptr             <= PW'(NCH - 1);
      sel             <= '0;
      len_q           <= '0;
      words_left      <= '0;
      gap_cnt         <= '0;
      dst_port        <= '0;
      tx_data_length  <= '0;
      tx_total_length <= '0;
    end else begin
      state <= state_nxt;
      if (|ch_grant || |ch_err) ptr <= arb_sel;
      if (|ch_grant) begin
        sel             <= arb_sel;
        len_q           <= arb_len;
        dst_port        <= arb_port;
        tx_data_length  <= arb_len + 16'd8;
        tx_total_length <= arb_len + 16'd28;
      end
      if (state == S_START) begin
        words_left <= (len_q + BPW_M1) >> LOG_BPW;
      end else if (state == S_DATA && tx_data_req) begin
        words_left <= words_left - 16'd1;
      end
      if (state == S_DATA && tx_data_req && words_left == 16'd1) begin
        gap_cnt <= GW'(IFG_CYC);
      end else if (state == S_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
    end
  end

`ifdef UDP_TX_SCHED_STATS_EN
  // Saturating per-channel counters of accepted and dropped requests
  always_ff @(posedge e_rxc or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_drops  <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (ch_grant[c] && stat_frames[16*c +: 16] != 16'hFFFF)
          stat_frames[16*c +: 16] <= stat_frames[16*c +: 16] + 16'd1;
        if (ch_err[c] && stat_drops[16*c +: 16] != 16'hFFFF)
          stat_drops[16*c +: 16] <= stat_drops[16*c +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/udp_tx_sched.md
Name: udp_tx_sched

Overview:
- Parametrised multi-channel transmit front end for the UDP/IP frame engine (`udp` core).
- Arbitrates up to NCH payload sources round-robin and drives the core's tx_start / tx_data_req / tx_data handshake.
- Per frame, computes tx_data_length and tx_total_length and selects the destination port.
- Rejects illegal lengths and enforces a programmable inter-frame gap, so upstream producers (FFT/radar cube readers) need no knowledge of framing.

Parameters:
- NCH, 4: number of source channels (1..8).
- DW, 32: word width toward the core, in bits. Legal values 8, 16 or 32.
- MAX_LEN, 1472: maximum legal payload, in bytes.
- IFG_CYC, 12: idle cycles enforced after the last payload word, before the next arbitration.

Ports:
- e_rxc  in  1  clock; all logic in this domain.
- rst_n  in  1  asynchronous active-low reset.
- ch_req  in  NCH  per-channel frame request, level; held until ch_grant or ch_err.
- ch_len  in  NCH*16  per-channel payload byte count; sampled at grant.
- ch_dst_port  in  NCH*16  per-channel UDP destination port; sampled at grant.
- ch_data  in  NCH*DW  per-channel payload word.
- ch_grant  out  NCH  one-cycle pulse: frame accepted.
- ch_err  out  NCH  one-cycle pulse: request dropped, illegal length.
- ch_data_req  out  NCH  word strobe to the granted channel.
- busy  out  1  high in any state other than IDLE.
- tx_start  out  1  one-cycle start pulse to the core.
- tx_data_req  in  1  word request from the core.
- tx_data  out  DW  payload word to the core.
- tx_data_length  out  16  UDP length = len+8.
- tx_total_length  out  16  IP total length = len+28.
- dst_port  out  16  latched destination port.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = NCH-1, so channel 0 wins first. Reset asserted mid-frame aborts immediately; no further tx_start or ch_data_req until requests reappear after reset.
- States: IDLE -> START -> DATA -> GAP -> IDLE.
- IDLE: if any ch_req is set, select the first requester after the pointer (wrapping); pointer := selected channel.
  - If ch_len == 0 or ch_len > MAX_LEN: pulse ch_err[sel] for one cycle and stay in IDLE. Next arbitration happens on the following cycle.
  - Otherwise: pulse ch_grant[sel]; register sel, len, dst_port, tx_data_length, tx_total_length (16-bit adds; no overflow possible because len <= MAX_LEN); go to START.
- START: tx_start = 1 for exactly one cycle. words_left := ceil(len/(DW/8)), i.e. (len + DW/8 - 1) >> log2(DW/8). Go to DATA.
- DATA:
  - ch_data_req[sel] = tx_data_req, combinational, same cycle.
  - tx_data = ch_data[sel], combinational mux. The source must present word k before strobe k and advance on the strobe.
  - Each tx_data_req decrements words_left. The cycle that consumes the last word moves to GAP with gap_cnt := IFG_CYC.
  - Final-word bytes beyond len are don't-care; the core truncates.
- GAP: decrement gap_cnt; go to IDLE when it reaches 0. IFG_CYC = 0 returns to IDLE on the next cycle.
- Outside DATA:
  - tx_data_req is ignored.
  - ch_data_req = 0 and tx_data = 0.
  - ch_req changes on non-selected channels have no effect.
- dst_port / tx_data_length / tx_total_length: registered, updated only at grant, held stable until the next grant.
- Fairness: a channel that has just been served has lowest priority at the next arbitration. Dropped (ch_err) requests also advance the pointer.
- Minimum frame-to-frame spacing: grant + start + words + IFG_CYC + 1 cycles.

Optional Feature:
- Macro: UDP_TX_SCHED_STATS_EN.
- Defined: adds outputs stat_frames (NCH*16) and stat_drops (NCH*16).
  - Per-channel counters increment on ch_grant / ch_err respectively, and saturate at 16'hFFFF.
  - Reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- NCH=4, DW=32, ch_req[0]=1, len=100, port 5000:
  - ch_grant[0] pulse; tx_start pulse the next cycle.
  - Exactly 25 ch_data_req[0] strobes.
  - tx_data_length=108, tx_total_length=128, dst_port=5000.
  - busy drops IFG_CYC+1 cycles after the last word.
- ch_req=4'b0111 held, all len=16 -> grants in order 0,1,2,0,1,2; no channel served twice while another waits.
- ch_req[2]=1, len=0, then len=1473 -> two ch_err[2] pulses; no tx_start; ch_grant stays 0.
- DW=32, len=5 -> 2 words; DW=8, len=5 -> 5 words; tx_data equals ch_data of the granted channel on every strobe.
- Assert rst_n=0 on the 3rd DATA word of a 100-byte frame:
  - All outputs 0 asynchronously.
  - After release with ch_req[1] only, channel 1 is granted and a fresh 25-word frame runs.
- With UDP_TX_SCHED_STATS_EN: 3 good frames and 1 bad length on channel 3 -> stat_frames[3]=3, stat_drops[3]=1, other channels 0.
